// File: rtl/id_inst_queue_pkg.sv
// Shared defaults for the IF/ID instruction queue.
// The top module takes its parameter defaults from here so other pipeline stages can size against the same values.
package id_inst_queue_pkg;

   localparam int IQ_DEPTH  = 4;
   localparam int IQ_PC_W   = 32;
   localparam int IQ_INST_W = 32;

endpackage : id_inst_queue_pkg

// File: rtl/id_iq_mem.sv
// Storage array for the instruction queue: one write port, one asynchronous read port.
// There is no reset; the owner gates the outputs with its occupancy count so stale entries never show.
module id_iq_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : id_iq_mem

// File: rtl/id_inst_queue.sv
// DEPTH-entry FIFO of {pc, inst} pairs between IF and ID. It absorbs the one-cycle instruction SRAM latency,
// decouples IF from ID stalls and drops all queued and in-flight fetches on a branch flush.
module id_inst_queue
   import id_inst_queue_pkg::*;
#(
   parameter int DEPTH  = IQ_DEPTH,
   parameter int PC_W   = IQ_PC_W,
   parameter int INST_W = IQ_INST_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     if_valid,
   input  logic [PC_W-1:0]          if_pc,
   output logic                     if_ready,
   input  logic [INST_W-1:0]        inst_sram_rdata,
   input  logic                     flush,
   output logic                     id_valid,
   output logic [PC_W-1:0]          id_pc,
   output logic [INST_W-1:0]        id_inst,
   input  logic                     id_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW       = $clog2(DEPTH);
   localparam int CW       = AW + 1;
   localparam int ENTRY_WD = PC_W + INST_W;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic                pend_v;
   logic [PC_W-1:0]     pend_pc;
   logic [CW:0]         occupancy;
   logic                accept;
   logic                push;
   logic                pop;
   logic [ENTRY_WD-1:0] head;

   // The fetch in flight already owns a slot, so it counts as occupied; a same-cycle pop is not credited.
   assign occupancy = {1'b0, count} + (CW+1)'(pend_v);
   assign if_ready  = ~flush & (occupancy < DEPTH_L);
   assign accept    = if_valid & if_ready;
   assign push      = pend_v & ~flush;
   assign pop       = id_valid & id_ready & ~flush;

   assign id_valid  = (count != '0);
   assign id_pc     = id_valid ? head[ENTRY_WD-1:INST_W] : '0;
   assign id_inst   = id_valid ? head[INST_W-1:0]        : '0;

   // Track the SRAM read issued last cycle so its data can be paired with its PC on arrival.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_v  <= 1'b0;
         pend_pc <= '0;
      end else begin
         pend_v <= accept;
         if (accept) begin
            pend_pc <= if_pc;
         end
      end
   end

   // Flush rewinds both pointers and empties the queue, overriding any push or pop that cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   id_iq_mem #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_WD)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata ({pend_pc, inst_sram_rdata}),
      .raddr (rd_ptr),
      .rdata (head)
   );

endmodule : id_inst_queue

// File: tb/tb_id_inst_queue.sv
// Self-checking bench for id_inst_queue at DEPTH = 4: a table of per-cycle vectors plus
// hand-written sequences for pointer wrap under random back-pressure and asynchronous reset.
module tb_id_inst_queue;

   localparam int DEPTH  = 4;
   localparam int PC_W   = 32;
   localparam int INST_W = 32;

   logic              clk;
   logic              rst;
   logic              if_valid;
   logic [PC_W-1:0]   if_pc;
   logic              if_ready;
   logic [INST_W-1:0] inst_sram_rdata;
   logic              flush;
   logic              id_valid;
   logic [PC_W-1:0]   id_pc;
   logic [INST_W-1:0] id_inst;
   logic              id_ready;
   logic [2:0]        count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        if_valid;
      logic [31:0] if_pc;
      logic [31:0] rdata;
      logic        flush;
      logic        id_ready;
      logic        exp_if_ready;
      logic        exp_id_valid;
      logic [31:0] exp_id_pc;
      logic [31:0] exp_id_inst;
      logic [31:0] exp_count;
   } vec_t;

   vec_t vecs[$];

   id_inst_queue #(
      .DEPTH  (DEPTH),
      .PC_W   (PC_W),
      .INST_W (INST_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .if_valid        (if_valid),
      .if_pc           (if_pc),
      .if_ready        (if_ready),
      .inst_sram_rdata (inst_sram_rdata),
      .flush           (flush),
      .id_valid        (id_valid),
      .id_pc           (id_pc),
      .id_inst         (id_inst),
      .id_ready        (id_ready),
      .count           (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag, input int idx);
      check_output({tag, "_id_valid"}, idx, 32'(id_valid), 32'd0);
      check_output({tag, "_id_pc"},    idx, id_pc,          32'd0);
      check_output({tag, "_id_inst"},  idx, id_inst,        32'd0);
      check_output({tag, "_count"},    idx, 32'(count),     32'd0);
      check_output({tag, "_if_ready"}, idx, 32'(if_ready),  32'd1);
   endtask

   function automatic void add_vec(input logic iv, input logic [31:0] pc, input logic [31:0] rd,
                                   input logic fl, input logic ir, input logic e_ifr, input logic e_idv,
                                   input logic [31:0] e_pc, input logic [31:0] e_inst, input logic [31:0] e_cnt);
      vec_t v;
      v.if_valid = iv;   v.if_pc = pc;         v.rdata = rd;
      v.flush = fl;      v.id_ready = ir;
      v.exp_if_ready = e_ifr; v.exp_id_valid = e_idv;
      v.exp_id_pc = e_pc;     v.exp_id_inst = e_inst; v.exp_count = e_cnt;
      vecs.push_back(v);
   endfunction

   // One vector per cycle: drive 1 time unit after posedge, compare just before the next negedge.
   task automatic apply_stimulus(input vec_t v, input int idx);
      @(posedge clk);
      #1;
      if_valid        = v.if_valid;
      if_pc           = v.if_pc;
      inst_sram_rdata = v.rdata;
      flush           = v.flush;
      id_ready        = v.id_ready;
      #2;
      check_output("vec_if_ready", idx, 32'(if_ready), 32'(v.exp_if_ready));
      check_output("vec_id_valid", idx, 32'(id_valid), 32'(v.exp_id_valid));
      check_output("vec_id_pc",    idx, id_pc,         v.exp_id_pc);
      check_output("vec_id_inst",  idx, id_inst,       v.exp_id_inst);
      check_output("vec_count",    idx, 32'(count),    v.exp_count);
   endtask

   initial begin
      int model_cnt;
      int popped;
      int issued;
      int cyc;
      logic pend;
      logic [31:0] pend_pc;
      logic acc;
      logic pop;
      logic [31:0] sb[$];
      logic [31:0] exp_pc;

      // Streaming, then empty pop
      add_vec(1, 32'h00, 32'h000, 0, 1,  1, 0, 32'h00, 32'h000, 0);
      add_vec(1, 32'h04, 32'h100, 0, 1,  1, 0, 32'h00, 32'h000, 0);
      add_vec(1, 32'h08, 32'h104, 0, 1,  1, 1, 32'h00, 32'h100, 1);
      add_vec(0, 32'h00, 32'h108, 0, 1,  1, 1, 32'h04, 32'h104, 1);
      add_vec(0, 32'h00, 32'h000, 0, 1,  1, 1, 32'h08, 32'h108, 1);
      add_vec(0, 32'h00, 32'h000, 0, 1,  1, 0, 32'h00, 32'h000, 0);
      add_vec(0, 32'h00, 32'h000, 0, 1,  1, 0, 32'h00, 32'h000, 0);
      // Fill to DEPTH with no pops, then a single pop
      add_vec(1, 32'h10, 32'h000, 0, 0,  1, 0, 32'h00, 32'h000, 0);
      add_vec(1, 32'h14, 32'h110, 0, 0,  1, 0, 32'h00, 32'h000, 0);
      add_vec(1, 32'h18, 32'h114, 0, 0,  1, 1, 32'h10, 32'h110, 1);
      add_vec(1, 32'h1c, 32'h118, 0, 0,  1, 1, 32'h10, 32'h110, 2);
      add_vec(1, 32'h20, 32'h11c, 0, 0,  0, 1, 32'h10, 32'h110, 3);
      add_vec(1, 32'h20, 32'h120, 0, 0,  0, 1, 32'h10, 32'h110, 4);
      add_vec(1, 32'h20, 32'h120, 0, 0,  0, 1, 32'h10, 32'h110, 4);
      add_vec(0, 32'h00, 32'h000, 0, 1,  0, 1, 32'h10, 32'h110, 4);
      // Accept one more so count = 3 with a fetch in flight, then flush
      add_vec(1, 32'h24, 32'h000, 0, 0,  1, 1, 32'h14, 32'h114, 3);
      add_vec(1, 32'h40, 32'h124, 1, 1,  0, 1, 32'h14, 32'h114, 3);
      add_vec(1, 32'h80, 32'h000, 0, 0,  1, 0, 32'h00, 32'h000, 0);
      add_vec(0, 32'h00, 32'h180, 0, 0,  1, 0, 32'h00, 32'h000, 0);
      add_vec(0, 32'h00, 32'h000, 0, 1,  1, 1, 32'h80, 32'h180, 1);
      add_vec(0, 32'h00, 32'h000, 0, 0,  1, 0, 32'h00, 32'h000, 0);

      if_valid = 0; if_pc = '0; inst_sram_rdata = '0; flush = 0; id_ready = 0;
      rst = 1;
      #12;
      check_reset_outputs("reset", 0);
      @(posedge clk);
      #1;
      rst = 0;

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i], i);
      end

      // Wrap: 10 entries through the queue with random back-pressure against a scoreboard
      model_cnt = 0; popped = 0; issued = 0; cyc = 0;
      pend = 0; pend_pc = '0;
      while (popped < 10 && cyc < 300) begin
         @(posedge clk);
         #1;
         inst_sram_rdata = pend_pc + 32'h1000;
         if_valid        = (issued < 10);
         if_pc           = 32'h200 + 32'(issued) * 4;
         flush           = 0;
         id_ready        = 1'($urandom_range(0, 1));
         #2;
         check_output("wrap_count",    cyc, 32'(count),    32'(model_cnt));
         check_output("wrap_if_ready", cyc, 32'(if_ready), 32'((model_cnt + int'(pend)) < DEPTH));
         if (count > 3'(DEPTH)) begin
            check_output("wrap_count_bound", cyc, 32'(count), 32'(DEPTH));
         end
         acc = if_valid && if_ready;
         pop = (model_cnt != 0) && id_ready;
         if (pop) begin
            exp_pc = sb.pop_front();
            check_output("wrap_id_pc",   popped, id_pc,   exp_pc);
            check_output("wrap_id_inst", popped, id_inst, exp_pc + 32'h1000);
            popped++;
         end
         if (acc) begin
            sb.push_back(if_pc);
            issued++;
         end
         model_cnt = model_cnt + int'(pend) - int'(pop);
         pend      = acc;
         pend_pc   = if_pc;
         cyc++;
      end
      check_output("wrap_done", 0, 32'(popped), 32'd10);

      // Async reset mid-stream with entries queued and a fetch in flight
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if_valid = 1; if_pc = 32'h300 + 32'(i) * 4; inst_sram_rdata = 32'h2300 + 32'(i) * 4;
         id_ready = 0; flush = 0;
      end
      @(posedge clk);
      #1;
      if_valid = 0;
      inst_sram_rdata = 32'h2308;
      #2;
      check_output("pre_rst_count", 0, 32'(count), 32'd2);
      rst = 1;
      #1;
      check_reset_outputs("async_rst", 0);
      @(posedge clk);
      #1;
      rst = 0;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk);
         #2;
         check_reset_outputs("post_rst", i);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_id_inst_queue
